// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x oversampled UART receiver.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  // Counter value at which the start bit is tested. It lands on pin sample 7.
  // The synchroniser delay shifts every sample by the same amount.
  function automatic int mid_cnt(int os);
    return os / 2 - 2;
  endfunction

  localparam int MID_CNT_DEF = mid_cnt(OVERSAMPLE_DEF);

endpackage

// File: rtl/uart_rx_os16_if.sv
// Received-byte bundle of uart_rx_os16; framing_error only exists when
// UART_RX_FRAMING_ERR_EN is defined.
interface uart_rx_os16_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] data;
  logic                 data_valid;

`ifdef UART_RX_FRAMING_ERR_EN
  logic framing_error;

  modport master (
    output data,
    output data_valid,
    output framing_error
  );

  modport slave (
    input data,
    input data_valid,
    input framing_error
  );
`else
  modport master (
    output data,
    output data_valid
  );

  modport slave (
    input data,
    input data_valid
  );
`endif

endinterface

// File: rtl/uart_sync.sv
// Multi-stage synchroniser for the asynchronous serial line.
// Reset sets every stage to 1, the idle level of the line.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_os16.sv
// UART 8N1 receiver with 16x oversampling; MSB-first shift.
// Define UART_RX_FRAMING_ERR_EN to add the framing_error pulse.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           raw_data,
  uart_rx_os16_if.master rx
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] MID   = CW'(mid_cnt(OVERSAMPLE));
  localparam logic [CW-1:0] LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

  logic rx_s;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 armed_q, armed_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (raw_data),
    .dout  (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    armed_d = armed_q;
    valid_d = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A break must return high before a new start is accepted.
        armed_d = armed_q | rx_s;
        if (armed_q && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
          armed_d = 1'b0;
        end
      end
      START: begin
        if (cnt_q == MID) begin
          cnt_d = '0;
          bit_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {shift_q[DATA_BITS-2:0], rx_s};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BLAST) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      armed_q <= 1'b0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      armed_q <= armed_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
    end
  end

  assign rx.data       = data_q;
  assign rx.data_valid = valid_q;

`ifdef UART_RX_FRAMING_ERR_EN
  assign rx.framing_error = fe_q;
`else
  logic unused_fe;
  assign unused_fe = fe_q;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Scoreboard bench for uart_rx_os16: directed frames in, monitor pops
// expected bytes and pulse timing on every data_valid strobe.
module tb_uart_rx_os16;

  localparam int DW = 8;
  localparam int OS = 16;

  typedef struct {
    logic [DW-1:0] b;
    int            t;
  } exp_t;

  logic clk      = 1'b0;
  logic rst_n    = 1'b1;
  logic raw_data = 1'b1;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   fe_cnt = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_os16_if #(.DATA_BITS(DW)) rx_if ();

  uart_rx_os16 #(
    .OVERSAMPLE  (OS),
    .DATA_BITS   (DW),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_data (raw_data),
    .rx       (rx_if)
  );

  always @(negedge clk) begin
    if (rx_if.data_valid === 1'b1) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid data=%h cyc=%0d",
                 rx_if.data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        // Pulse must sit near the middle of the stop bit.
        if (rx_if.data !== mon_e.b ||
            (cyc - mon_e.t) < 8 || (cyc - mon_e.t) > 11) begin
          errors++;
          $display("FAIL byte got=%h at+%0d want=%h at+8..11",
                   rx_if.data, cyc - mon_e.t, mon_e.b);
        end
      end
    end
  end

`ifdef UART_RX_FRAMING_ERR_EN
  always @(negedge clk) begin
    if (rx_if.framing_error === 1'b1) fe_cnt++;
  end
`endif

  task automatic check(string name, int got, int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic idle(int n);
    raw_data = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(logic v, bit mal);
    for (int s = 0; s < OS; s++) begin
      if (mal) raw_data = (s >= 6 && s <= 9) ? v : ~v;
      else     raw_data = v;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(logic [DW-1:0] b, logic stop, bit mal);
    send_bit(1'b0, 1'b0);
    for (int i = DW - 1; i >= 0; i--) send_bit(b[i], mal);
    if (stop) exp_q.push_back('{b: b, t: cyc + 1});
    send_bit(stop, 1'b0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 600; i++) begin
      raw_data = (i < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    check("rst_data", int'(rx_if.data), 0);
    check("rst_valid", int'(rx_if.data_valid), 0);
    check("rst_pulses", pulses, 0);
    raw_data = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    idle(1000);
    check("idle_pulses", pulses, 0);

    send_frame(8'b1101_0101, 1'b1, 1'b0);
    idle(20);
    check("clean_pulses", pulses, 1);
    check("clean_data", int'(rx_if.data), 8'hD5);

    send_frame(8'b1101_0101, 1'b1, 1'b0);
    idle(10);
    send_frame(8'b1100_0101, 1'b1, 1'b0);
    idle(20);
    check("pair_pulses", pulses, 3);

    send_frame(8'b1101_0101, 1'b0, 1'b0);
    idle(200);
    check("ferr_pulses", pulses, 3);
    check("ferr_data_kept", int'(rx_if.data), 8'hC5);
`ifdef UART_RX_FRAMING_ERR_EN
    check("ferr_flag", fe_cnt, 1);
`endif

    send_frame(8'b1101_0101, 1'b1, 1'b1);
    idle(20);
    check("malformed_pulses", pulses, 4);
    check("malformed_data", int'(rx_if.data), 8'hD5);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);
    check("b2b_pulses", pulses, 7);
    check("b2b_data", int'(rx_if.data), 8'hA5);

    raw_data = 1'b0;
    repeat (400) @(negedge clk);
    check("break_pulses", pulses, 7);
`ifdef UART_RX_FRAMING_ERR_EN
    check("break_flag", fe_cnt, 2);
`endif
    idle(50);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20);
    check("after_break", pulses, 8);

    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_data", int'(rx_if.data), 0);
    check("midrst_valid", int'(rx_if.data_valid), 0);
    raw_data = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(30);
    send_frame(8'h96, 1'b1, 1'b0);
    idle(20);
    check("midrst_recover", pulses, 9);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- UART byte receiver for the serial input path: start bit, 8 data bits, 1 stop bit, no parity.
- raw_data is an asynchronous line oversampled by clk at 16 samples per bit; the bit rate is clk/16.
- The block resynchronises the line, detects the start bit and samples each bit near its centre.
- On a good stop bit it presents the byte on data with a single-cycle data_valid strobe.

Parameters:
- OVERSAMPLE, 16, clk cycles per UART bit (power of two, >=8).
- DATA_BITS, 8, data bits per frame.
- SYNC_STAGES, 2, flip-flops in the raw_data synchroniser (>=2).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- raw_data  input  1  serial line, idle high, asynchronous to clk.
- data  output  DATA_BITS  last correctly framed byte.
- data_valid  output  1  one-cycle strobe: data updated this cycle.

Behaviour:
- Reset (rst_n low, any time including mid-frame):
  - data=0, data_valid=0, state=IDLE.
  - Synchroniser flops preset to 1 (idle).
  - Outputs stay 0 for as long as rst_n is held low, regardless of raw_data.
- raw_data passes through SYNC_STAGES flops; all decisions use the synchronised value rx_s.
- Sample-position reference: index 0 is the first low sample of the start bit at the raw_data pin. All data/stop samples must take the pin value at bit-sample index 7 (±1 tolerated; never outside 6..9), with synchroniser latency compensated.
- States:
  - IDLE: armed only after rx_s has been seen high at least once since reset or the last frame. Armed and rx_s==0 -> START; clear the sample counter.
  - START: count to mid-bit. If rx_s==1 at mid-start, it is a false start -> IDLE with no output. Else -> DATA with bit counter=0.
  - DATA: every OVERSAMPLE cycles take one sample; shift in MSB-first (first received bit lands in data[DATA_BITS-1]). After DATA_BITS samples -> STOP.
  - STOP: at mid-stop, if rx_s==1, load data from the shift register and assert data_valid for exactly one cycle. If rx_s==0 it is a framing error: data is unchanged and data_valid stays 0. Either way -> IDLE, which re-arms on line high.
- data_valid rises at the middle of the stop bit, about OVERSAMPLE/2+SYNC_STAGES cycles after the stop bit starts at the pin; this is well before the stop bit ends.
- Back-to-back frames: a new start edge may arrive any time after mid-stop once the line has gone high; no extra idle time is required.
- Sustained low line (break) produces no output and no retrigger until the line returns high.
- Counters use $clog2(OVERSAMPLE) and $clog2(DATA_BITS+1) bits. No overflow beyond the frame.

Optional Feature:
- UART_RX_FRAMING_ERR_EN defined: adds output port framing_error (1 bit, reset 0). It pulses for one cycle at mid-stop when the stop sample is 0, in the cycle where data_valid would otherwise have fired.
- Undefined: the port is absent and bad frames are silently dropped.

Decomposition:
- Package uart_pkg holds the state enum {IDLE, START, DATA, STOP}, the OVERSAMPLE default, and localparams for the mid-bit count.
- One sub-module, uart_sync, is the SYNC_STAGES-deep reset-to-1 synchroniser.
- Everything else lives in uart_rx_os16.

Test Plan:
- rst_n held low 600 cycles, raw_data toggled or held 0 -> data_valid never 1; data=0.
- Idle line high 1000 cycles after reset -> data_valid never 1.
- Clean frame (start, bits 1,1,0,1,0,1,0,1, stop=1, 16 samples each) -> exactly one data_valid pulse during the stop bit, data=8'b1101_0101.
- Two frames separated by 10 idle cycles -> 8'b1101_0101 then 8'b1100_0101, one pulse each.
- Same frame with stop bit 0, then 200 idle cycles -> data_valid never 1; framing_error pulses once if UART_RX_FRAMING_ERR_EN is defined.
- Malformed bits with the correct value only at samples 6..9 of each 16 (e.g. '1' = 0000_0011_1100_0000 in time order) -> data=8'b1101_0101.
